// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle controller and the RV32I datapath.
// The controller (master) consumes IR fields and the zero flag and drives every select and strobe.
interface multicycle_controller_if #(
   parameter int STATE_W = 4
);
   logic [6:0]         op;
   logic [2:0]         funct3;
   logic               funct7b5;
   logic               zero;

   logic               PCWrite;
   logic               AdrSrc;
   logic               MemWrite;
   logic               IRWrite;
   logic               RegWrite;
   logic [1:0]         ResultSrc;
   logic [1:0]         ALUSrcA;
   logic [1:0]         ALUSrcB;
   logic [2:0]         ALUControl;
   logic [1:0]         ImmSrc;
   logic [STATE_W-1:0] state;

   modport master (
      input  op, funct3, funct7b5, zero,
      output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
             ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc, state
   );

   modport slave (
      output op, funct3, funct7b5, zero,
      input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
             ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc, state
   );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle RV32I control unit: Moore main FSM plus combinational ALU and immediate decoders.
// state    | meaning
// FETCH    | read instruction at PC, latch IR/OldPC, PC <= PC+4
// DECODE   | read registers, compute branch/jump target OldPC+imm
// MEMADR   | rs1 + imm address for lw/sw
// MEMREAD  | present ALUOut as data address
// MEMWB    | write loaded data to rd
// MEMWRITE | store rs2 to memory
// EXECR    | R-type ALU operation
// EXECI    | I-type ALU operation
// ALUWB    | write ALUOut to rd
// BEQ      | compare rs1/rs2, take branch on zero
// JAL      | PC <= target, compute link OldPC+4
module multicycle_controller #(
   parameter int STATE_W = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   multicycle_controller_if.master ctl
);

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEMADR   = 4'd2,
      MEMREAD  = 4'd3,
      MEMWB    = 4'd4,
      MEMWRITE = 4'd5,
      EXECR    = 4'd6,
      EXECI    = 4'd7,
      ALUWB    = 4'd8,
      BEQ      = 4'd9,
      JAL      = 4'd10
   } state_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   state_t     state_q;
   state_t     state_d;
   logic [1:0] alu_op;
   logic       branch;
   logic       pc_update;
   logic       ir_write;
   logic       mem_write;
   logic       reg_write;
   logic       adr_src;
   logic [1:0] result_src;
   logic [1:0] alu_src_a;
   logic [1:0] alu_src_b;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d    = FETCH;
      alu_op     = 2'b00;
      branch     = 1'b0;
      pc_update  = 1'b0;
      ir_write   = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      adr_src    = 1'b0;
      result_src = 2'b00;
      alu_src_a  = 2'b00;
      alu_src_b  = 2'b00;
      case (state_q)
         FETCH: begin
            ir_write   = 1'b1;
            alu_src_b  = 2'b10;
            result_src = 2'b10;
            pc_update  = 1'b1;
            state_d    = DECODE;
         end
         DECODE: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b01;
            case (ctl.op)
               OP_LOAD, OP_STORE: state_d = MEMADR;
               OP_RTYPE:          state_d = EXECR;
               OP_ITYPE:          state_d = EXECI;
               OP_BRANCH:         state_d = BEQ;
               OP_JAL:            state_d = JAL;
               default:           state_d = FETCH;
            endcase
         end
         MEMADR: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b01;
            state_d   = (ctl.op == OP_LOAD) ? MEMREAD : MEMWRITE;
         end
         MEMREAD: begin
            adr_src    = 1'b1;
            result_src = 2'b00;
            state_d    = MEMWB;
         end
         MEMWB: begin
            result_src = 2'b01;
            reg_write  = 1'b1;
            state_d    = FETCH;
         end
         MEMWRITE: begin
            adr_src   = 1'b1;
            mem_write = 1'b1;
            state_d   = FETCH;
         end
         EXECR: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b00;
            alu_op    = 2'b10;
            state_d   = ALUWB;
         end
         EXECI: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b01;
            alu_op    = 2'b10;
            state_d   = ALUWB;
         end
         ALUWB: begin
            result_src = 2'b00;
            reg_write  = 1'b1;
            state_d    = FETCH;
         end
         BEQ: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b00;
            alu_op    = 2'b01;
            branch    = 1'b1;
            state_d   = FETCH;
         end
         JAL: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b10;
            pc_update = 1'b1;
            state_d   = ALUWB;
         end
         default: state_d = FETCH;
      endcase
   end

   // Architectural strobes are gated by reset so nothing commits while the core is held.
   assign ctl.PCWrite   = ~reset & (pc_update | (branch & ctl.zero));
   assign ctl.IRWrite   = ~reset & ir_write;
   assign ctl.MemWrite  = ~reset & mem_write;
   assign ctl.RegWrite  = ~reset & reg_write;
   assign ctl.AdrSrc    = adr_src;
   assign ctl.ResultSrc = result_src;
   assign ctl.ALUSrcA   = alu_src_a;
   assign ctl.ALUSrcB   = alu_src_b;
   assign ctl.state     = STATE_W'(state_q);

   always_comb begin
      ctl.ALUControl = 3'b000;
      case (alu_op)
         2'b01: ctl.ALUControl = 3'b001;
         2'b10: begin
            case (ctl.funct3)
               3'b000:  ctl.ALUControl = (ctl.op[5] & ctl.funct7b5) ? 3'b001 : 3'b000;
               3'b010:  ctl.ALUControl = 3'b101;
               3'b110:  ctl.ALUControl = 3'b011;
               3'b111:  ctl.ALUControl = 3'b010;
               default: ctl.ALUControl = 3'b000;
            endcase
         end
         default: ctl.ALUControl = 3'b000;
      endcase
   end

   always_comb begin
      ctl.ImmSrc = 2'b00;
      case (ctl.op)
         OP_LOAD, OP_ITYPE: ctl.ImmSrc = 2'b00;
         OP_STORE:          ctl.ImmSrc = 2'b01;
         OP_BRANCH:         ctl.ImmSrc = 2'b10;
         OP_JAL:            ctl.ImmSrc = 2'b11;
         default:           ctl.ImmSrc = 2'b00;
      endcase
   end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Control unit for the multicycle variant of the RV32I core.
- Sequences fetch, decode, execute, memory and writeback over multiple cycles using one shared ALU and one unified instruction/data memory.
- Drives the immediate-extender select (ImmSrc), the ALU operation, the datapath mux selects and all architectural write strobes.
- Sits between the instruction register and the datapath. Inputs are the IR opcode/funct fields and the ALU zero flag.

Parameters:
- STATE_W, 4, width of the state register and of the debug state output (fixed at 4; 11 states used).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- op  in  7  Instr[6:0] from the instruction register
- funct3  in  3  Instr[14:12]
- funct7b5  in  1  Instr[30]
- zero  in  1  ALU result == 0
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut
- MemWrite  out  1  data memory write strobe
- IRWrite  out  1  instruction register / OldPC enable
- RegWrite  out  1  register file write strobe
- ResultSrc  out  2  result mux: 00 = ALUOut, 01 = Data, 10 = ALUResult
- ALUSrcA  out  2  00 = PC, 01 = OldPC, 10 = rs1 data
- ALUSrcB  out  2  00 = rs2 data, 01 = ImmExt, 10 = constant 4
- ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- ImmSrc  out  2  00 I, 01 S, 10 B, 11 J
- state  out  4  current state, for debug and verification

Behaviour:
- Reset (synchronous): on the first clk edge with reset=1, state <= FETCH (0).
  - While reset=1, PCWrite, IRWrite, MemWrite and RegWrite are forced to 0 regardless of state.
  - Reset asserted mid-instruction abandons the instruction; the next cycle after deassertion is FETCH.
- Moore outputs: AdrSrc, IRWrite, MemWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB and the internal ALUOp/Branch/PCUpdate depend on state only. Any signal not listed for a state is 0.
- Combinational outputs:
  - PCWrite = PCUpdate | (Branch & zero).
  - ImmSrc and ALUControl are driven from op/funct3/funct7b5 in the same cycle.
- State encoding, per-state outputs and next state:
  - 0 FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCUpdate=1. Next: DECODE.
  - 1 DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00. Next by op:
    - 0000011 or 0100011 → MEMADR
    - 0110011 → EXECR
    - 0010011 → EXECI
    - 1100011 → BEQ
    - 1101111 → JAL
    - any other op → FETCH (treated as a NOP; no write strobe ever asserted).
  - 2 MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Next: MEMREAD if op=0000011, else MEMWRITE.
  - 3 MEMREAD: AdrSrc=1, ResultSrc=00. Next: MEMWB.
  - 4 MEMWB: ResultSrc=01, RegWrite=1. Next: FETCH.
  - 5 MEMWRITE: AdrSrc=1, MemWrite=1. Next: FETCH.
  - 6 EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Next: ALUWB.
  - 7 EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Next: ALUWB.
  - 8 ALUWB: ResultSrc=00, RegWrite=1. Next: FETCH.
  - 9 BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, Branch=1. Next: FETCH.
  - 10 JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, PCUpdate=1. Next: ALUWB.
  - Encodings 11–15 are illegal; next state is FETCH and all strobes are 0.
- ImmSrc from op: 0000011/0010011 → 00; 0100011 → 01; 1100011 → 10; 1101111 → 11; any other op → 00.
- ALU decode:
  - ALUOp=00 → add.
  - ALUOp=01 → sub.
  - ALUOp=10, by funct3:
    - 000 → sub if (op[5] & funct7b5), else add
    - 010 → slt
    - 110 → or
    - 111 → and
    - other funct3 → add
- Instruction latency in cycles, counted from FETCH: lw 5, sw 4, R-type 4, I-ALU 4, beq 3, jal 4.
- Branch: PCWrite is asserted in BEQ only when zero=1 in that cycle. zero is sampled combinationally, not registered.

Test Plan:
- Reset: hold reset=1 for 2 cycles in arbitrary states → state=0, and PCWrite/IRWrite/MemWrite/RegWrite stay 0 throughout; after release, cycle 1 shows IRWrite=1, PCWrite=1.
- lw (op=0000011): states 0,1,2,3,4,0; ImmSrc=00; RegWrite=1 only in state 4 with ResultSrc=01; AdrSrc=1 in state 3.
- sw (op=0100011): states 0,1,2,5,0; MemWrite=1 exactly one cycle (state 5); ImmSrc=01; RegWrite never asserted.
- R-type sub (op=0110011, funct3=000, funct7b5=1) → ALUControl=001 in state 6. Same with op=0010011 and funct7b5=1 → ALUControl=000 (addi); funct3=010 → 101.
- beq (op=1100011) run twice: zero=1 → PCWrite=1 in state 9; zero=0 → PCWrite=0; ALUControl=001, ImmSrc=10 in both runs.
- jal (op=1101111): states 0,1,10,8,0; PCWrite=1 in state 10; ImmSrc=11. Illegal op=0000000: states 0,1,0 with no write strobe. Reset asserted in state 3 → state 0 next cycle.
